// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_e;

    // Bit positions inside the 8-bit status word.
    localparam int unsigned ST_ZERO    = 0;
    localparam int unsigned ST_INF     = 1;
    localparam int unsigned ST_NAN     = 2;
    localparam int unsigned ST_TINY    = 3;
    localparam int unsigned ST_HUGE    = 4;
    localparam int unsigned ST_INEXACT = 5;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int unsigned fp_prod_width(input int unsigned man_w);
        return 2 * (man_w + 1);
    endfunction

endpackage

// File: rtl/fp_mult_core.sv
// Combinational IEEE-754 multiply with FTZ inputs, flush-to-zero underflow and
// selectable rounding; any EXP_W/MAN_W format.
module fp_mult_core
    import fp_mult_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [fp_width(EXP_W, MAN_W)-1:0] a,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] b,
    input  logic [2:0]                        rnd,
    output logic [fp_width(EXP_W, MAN_W)-1:0] z,
    output logic [7:0]                        status
);

    localparam int unsigned W  = fp_width(EXP_W, MAN_W);
    localparam int unsigned PW = fp_prod_width(MAN_W);
    localparam int unsigned XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));
    localparam logic [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

    logic             sa, sb, s;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [PW-1:0]    prod;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign s      = sa ^ sb;
    // Denormal operands are treated as zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});

    logic             msb, guard, sticky, inc, to_inf, uflow, oflow;
    logic [MAN_W-1:0] frac;
    logic [MAN_W:0]   frac_r;
    logic [XW-1:0]    exp_n, exp_r;

    always_comb begin
        msb    = prod[PW-1];
        frac   = msb ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
        guard  = msb ? prod[MAN_W] : prod[MAN_W-1];
        sticky = msb ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
        exp_n  = {2'b00, ea} + {2'b00, eb} - BIAS_X + XW'(msb);

        unique case (rnd_e'(rnd))
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = ~s & (guard | sticky);
            IEEE_ninf: inc = s & (guard | sticky);
            near_up:   inc = guard;
            away_zero: inc = guard | sticky;
            default:   inc = guard & (sticky | frac[0]);
        endcase

        // A rounding carry leaves the fraction bits all zero, so only the exponent moves.
        frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        exp_r  = exp_n + XW'(frac_r[MAN_W]);
        uflow  = exp_r[XW-1] | (exp_r == '0);
        oflow  = ~exp_r[XW-1] & (exp_r >= EMAX_X);

        unique case (rnd_e'(rnd))
            IEEE_zero: to_inf = 1'b0;
            IEEE_pinf: to_inf = ~s;
            IEEE_ninf: to_inf = s;
            default:   to_inf = 1'b1;
        endcase

        z      = '0;
        status = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            z               = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            status[ST_NAN]  = 1'b1;
        end else if (a_inf || b_inf) begin
            z               = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            status[ST_INF]  = 1'b1;
        end else if (a_zero || b_zero) begin
            z               = {s, {(W-1){1'b0}}};
            status[ST_ZERO] = 1'b1;
        end else if (oflow) begin
            z = to_inf ? {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            status[ST_HUGE]    = 1'b1;
            status[ST_INEXACT] = 1'b1;
        end else if (uflow) begin
            z                  = {s, {(W-1){1'b0}}};
            status[ST_TINY]    = 1'b1;
            status[ST_INEXACT] = 1'b1;
        end else begin
            z                  = {s, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
            status[ST_INEXACT] = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined FP multiplier with valid/ready handshake and pass-through tag.
// FP_MULT_STICKY_STATUS_EN adds clr_sticky and an accumulated sticky_status output.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] a,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] b,
    input  logic [2:0]                        rnd,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [fp_width(EXP_W, MAN_W)-1:0] z,
    output logic [7:0]                        status,
    output logic [TAG_W-1:0]                  out_tag
`ifdef FP_MULT_STICKY_STATUS_EN
    ,
    input  logic                              clr_sticky,
    output logic [7:0]                        sticky_status
`endif
);

    localparam int unsigned W = fp_width(EXP_W, MAN_W);

    logic en;

    logic             s1_valid;
    logic [W-1:0]     s1_a, s1_b;
    logic [2:0]       s1_rnd;
    logic [TAG_W-1:0] s1_tag;

    logic [W-1:0] core_z;
    logic [7:0]   core_status;

    logic [STAGES:2]  vld;
    logic [W-1:0]     zq   [2:STAGES];
    logic [7:0]       stq  [2:STAGES];
    logic [TAG_W-1:0] tagq [2:STAGES];

    // Single global enable: the whole pipe freezes while the output beat is refused.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    fp_mult_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .rnd    (s1_rnd),
        .z      (core_z),
        .status (core_status)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rnd   <= '0;
            s1_tag   <= '0;
            for (int i = 2; i <= int'(STAGES); i++) begin
                vld[i]  <= 1'b0;
                zq[i]   <= '0;
                stq[i]  <= '0;
                tagq[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_rnd   <= rnd;
            s1_tag   <= in_tag;
            vld[2]   <= s1_valid;
            zq[2]    <= core_z;
            stq[2]   <= core_status;
            tagq[2]  <= s1_tag;
            for (int i = 3; i <= int'(STAGES); i++) begin
                vld[i]  <= vld[i-1];
                zq[i]   <= zq[i-1];
                stq[i]  <= stq[i-1];
                tagq[i] <= tagq[i-1];
            end
        end
    end

    assign out_valid = vld[STAGES];
    assign z         = zq[STAGES];
    assign status    = stq[STAGES];
    assign out_tag   = tagq[STAGES];

`ifdef FP_MULT_STICKY_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_status <= '0;
        end else if (clr_sticky) begin
            sticky_status <= '0;
        end else if (out_valid && out_ready) begin
            sticky_status <= sticky_status | status;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe (single precision, STAGES=3).
module tb_fp_mult_pipe;
    import fp_mult_pkg::*;

    localparam int STAGES = 3;

    localparam logic [7:0] S_ZERO = 8'h01;
    localparam logic [7:0] S_INF  = 8'h02;
    localparam logic [7:0] S_NAN  = 8'h04;
    localparam logic [7:0] S_TINY = 8'h08;
    localparam logic [7:0] S_HUGE = 8'h10;
    localparam logic [7:0] S_INEX = 8'h20;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, z;
    logic [2:0]  rnd;
    logic [3:0]  in_tag, out_tag;
    logic [7:0]  status;
`ifdef FP_MULT_STICKY_STATUS_EN
    logic        clr_sticky;
    logic [7:0]  sticky_status;
`endif

    int checks = 0;
    int errors = 0;

    fp_mult_pipe #(
        .EXP_W  (8),
        .MAN_W  (23),
        .STAGES (STAGES),
        .TAG_W  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .rnd           (rnd),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .z             (z),
        .status        (status),
        .out_tag       (out_tag)
`ifdef FP_MULT_STICKY_STATUS_EN
        ,
        .clr_sticky    (clr_sticky),
        .sticky_status (sticky_status)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one beat into an empty pipe and capture its result; lat = edges from accept.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [2:0] op_r, input logic [3:0] op_t,
                          output logic [31:0] rz, output logic [7:0] rs,
                          output logic [3:0] rt, output int lat);
        a = op_a; b = op_b; rnd = op_r; in_tag = op_t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid) begin
            rz = z; rs = status; rt = out_tag;
        end else begin
            rz = 'x; rs = 'x; rt = 'x; lat = -1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; rnd = IEEE_near; in_tag = '0;
`ifdef FP_MULT_STICKY_STATUS_EN
        clr_sticky = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (z !== 32'h0 || status !== 8'h0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: got z=%h st=%h tag=%h expected all 0", z, status, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef FP_MULT_STICKY_STATUS_EN
        checks++;
        if (sticky_status !== 8'h0) begin errors++; $display("FAIL reset_sticky: got %h expected 00", sticky_status); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rz; logic [7:0] rs; logic [3:0] rt; int lat;
        run_op(32'h3F800000, 32'h40000000, IEEE_near, 4'd5, rz, rs, rt, lat);
        checks++;
        if (rz !== 32'h40000000) begin errors++; $display("FAIL basic_z: got %h expected 40000000", rz); end
        checks++;
        if (rs !== 8'h00) begin errors++; $display("FAIL basic_status: got %h expected 00", rs); end
        checks++;
        if (rt !== 4'd5) begin errors++; $display("FAIL basic_tag: got %h expected 5", rt); end
        checks++;
        if (lat !== STAGES - 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, STAGES - 1); end
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  r;
        logic [31:0] z;
        logic [7:0]  st;
    } vec_t;

    task automatic test_arith();
        vec_t v [16];
        logic [31:0] rz; logic [7:0] rs; logic [3:0] rt; int lat;
        v[0]  = '{"ovf_near",   32'h7F7FFFFF, 32'h40000000, 3'(IEEE_near), 32'h7F800000, S_HUGE | S_INEX};
        v[1]  = '{"ovf_zero",   32'h7F7FFFFF, 32'h40000000, 3'(IEEE_zero), 32'h7F7FFFFF, S_HUGE | S_INEX};
        v[2]  = '{"ovf_neg_pi", 32'hFF7FFFFF, 32'h40000000, 3'(IEEE_pinf), 32'hFF7FFFFF, S_HUGE | S_INEX};
        v[3]  = '{"ovf_neg_ni", 32'hFF7FFFFF, 32'h40000000, 3'(IEEE_ninf), 32'hFF800000, S_HUGE | S_INEX};
        v[4]  = '{"tie_odd_ne", 32'h3F800001, 32'h3FC00000, 3'(IEEE_near), 32'h3FC00002, S_INEX};
        v[5]  = '{"tie_odd_rz", 32'h3F800001, 32'h3FC00000, 3'(IEEE_zero), 32'h3FC00001, S_INEX};
        v[6]  = '{"tie_even_n", 32'h3F800003, 32'h3FC00000, 3'(IEEE_near), 32'h3FC00004, S_INEX};
        v[7]  = '{"tie_even_u", 32'h3F800003, 32'h3FC00000, 3'(near_up),   32'h3FC00005, S_INEX};
        v[8]  = '{"rnd_code7",  32'h3F800003, 32'h3FC00000, 3'd7,          32'h3FC00004, S_INEX};
        v[9]  = '{"three_sq",   32'h40400000, 32'h40400000, 3'(IEEE_near), 32'h41100000, 8'h00};
        v[10] = '{"neg_prod",   32'hC0000000, 32'h40400000, 3'(IEEE_near), 32'hC0C00000, 8'h00};
        v[11] = '{"inf_x_zero", 32'h7F800000, 32'h00000000, 3'(IEEE_near), 32'h7FC00000, S_NAN};
        v[12] = '{"denorm_ftz", 32'h00000001, 32'h3F800000, 3'(IEEE_near), 32'h00000000, S_ZERO};
        v[13] = '{"nan_in",     32'h7FC00001, 32'h3F800000, 3'(IEEE_near), 32'h7FC00000, S_NAN};
        v[14] = '{"ninf_x_2",   32'hFF800000, 32'h40000000, 3'(IEEE_near), 32'hFF800000, S_INF};
        v[15] = '{"underflow",  32'h00800000, 32'h3F000000, 3'(IEEE_near), 32'h00000000, S_TINY | S_INEX};
        for (int i = 0; i < 16; i++) begin
            run_op(v[i].a, v[i].b, v[i].r, 4'(i), rz, rs, rt, lat);
            checks++;
            if (rz !== v[i].z) begin
                errors++; $display("FAIL %s_z: got %h expected %h", v[i].name, rz, v[i].z);
            end
            checks++;
            if (rs !== v[i].st) begin
                errors++; $display("FAIL %s_status: got %h expected %h", v[i].name, rs, v[i].st);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rcv = 0, c = 0;
        bit prev_stall = 0, saw_block = 0, acc, extra = 0;
        logic [31:0] held_z, exp_z;
        logic [3:0]  held_t;
        rnd = IEEE_near; a = 32'h3F800000;
        while (rcv < 8 && c < 60) begin
            out_ready = !(c >= 4 && c < 8);
            if (sent < 8) begin
                in_valid = 1'b1;
                b = 32'h40000000 | (32'(sent) << 16);
                in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) saw_block = 1;
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    checks++;
                    if (z !== held_z || out_tag !== held_t) begin
                        errors++;
                        $display("FAIL stall_hold: got z=%h tag=%h expected z=%h tag=%h", z, out_tag, held_z, held_t);
                    end
                end
                held_z = z; held_t = out_tag; prev_stall = 1;
            end else begin
                prev_stall = 0;
            end
            if (out_valid && out_ready) begin
                exp_z = 32'h40000000 | (32'(rcv) << 16);
                checks++;
                if (out_tag !== 4'(rcv)) begin errors++; $display("FAIL stream_tag: got %h expected %h", out_tag, 4'(rcv)); end
                checks++;
                if (z !== exp_z) begin errors++; $display("FAIL stream_z: got %h expected %h", z, exp_z); end
                rcv++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            #1;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (rcv !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", rcv); end
        checks++;
        if (!saw_block) begin errors++; $display("FAIL stream_backpressure: got in_ready always 1 expected 0 during stall"); end
        repeat (5) begin
            if (out_valid) extra = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL stream_duplicate: got extra beat expected none"); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rz; logic [7:0] rs; logic [3:0] rt; int lat;
        bit stale = 0;
        out_ready = 1'b1; in_valid = 1'b1; rnd = IEEE_near;
        a = 32'h3F800000; b = 32'h40000000; in_tag = 4'd1;
        @(posedge clk); #1;
        in_tag = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (z !== 32'h0 || out_tag !== 4'h0) begin
            errors++; $display("FAIL arst_data: got z=%h tag=%h expected 0", z, out_tag);
        end
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        repeat (6) begin
            if (out_valid) stale = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (stale) begin errors++; $display("FAIL arst_stale: got stale beat expected none"); end
        run_op(32'h40400000, 32'h40400000, IEEE_near, 4'd9, rz, rs, rt, lat);
        checks++;
        if (rz !== 32'h41100000 || rt !== 4'd9) begin
            errors++; $display("FAIL arst_next: got z=%h tag=%h expected z=41100000 tag=9", rz, rt);
        end
    endtask

`ifdef FP_MULT_STICKY_STATUS_EN
    task automatic test_sticky();
        logic [31:0] rz; logic [7:0] rs; logic [3:0] rt; int lat;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        run_op(32'h7F7FFFFF, 32'h40000000, IEEE_near, 4'd1, rz, rs, rt, lat);
        run_op(32'h3F800000, 32'h3F800000, IEEE_near, 4'd2, rz, rs, rt, lat);
        checks++;
        if (sticky_status !== (S_HUGE | S_INEX)) begin
            errors++; $display("FAIL sticky_accum: got %h expected %h", sticky_status, S_HUGE | S_INEX);
        end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (sticky_status !== 8'h00) begin errors++; $display("FAIL sticky_clear: got %h expected 00", sticky_status); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_back_to_back();
        test_async_reset();
`ifdef FP_MULT_STICKY_STATUS_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
